// File: rtl/rt_mon_pkg.sv
// Shared types and helpers for the multi-channel round-trip latency monitor.
package rt_mon_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int SUM_W          = 2 * DEF_DATA_WIDTH;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Requests per batch: batch length divided by 2**log2n, rounded up.
  function automatic logic [31:0] ceil_shift(input logic [31:0] len, input int unsigned log2n);
    logic [32:0] rounded;
    rounded = {1'b0, len} + ((33'd1 << log2n) - 33'd1);
    return 32'(rounded >> log2n);
  endfunction

endpackage

// File: rtl/rt_mon_channel.sv
// One monitor channel: timestamp FIFO, latency accumulators and a restoring divider
// that publishes avg/min/max at the end of every batch.
module rt_mon_channel
  import rt_mon_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int MAX_OUTSTANDING = 4,
  parameter int LOG2_N_CORES    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  req,
  input  logic                  resp,
  input  logic [DATA_WIDTH-1:0] now,
  input  logic [DATA_WIDTH-1:0] batch_length,
  output logic [DATA_WIDTH-1:0] avg,
  output logic [DATA_WIDTH-1:0] lat_min,
  output logic [DATA_WIDTH-1:0] lat_max,
  output logic                  valid,
  output logic                  err,
  output logic [1:0]            div_state
);

  localparam int W  = DATA_WIDTH;
  localparam int SW = 2 * DATA_WIDTH;
  localparam int AW = $clog2(MAX_OUTSTANDING);
  localparam int IW = $clog2(SW);
  localparam logic [AW:0]   DEPTH     = (AW + 1)'(MAX_OUTSTANDING);
  localparam logic [IW-1:0] LAST_ITER = IW'(SW - 1);

  // ---------------- timestamp FIFO ----------------
  logic [W-1:0]  fifo_mem [MAX_OUTSTANDING];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   occ;
  logic          fifo_empty, fifo_full;
  logic          do_push, do_pop, sample, fifo_err;
  logic [W-1:0]  lat;

  always_comb begin
    do_push    = 1'b0;
    do_pop     = 1'b0;
    sample     = 1'b0;
    fifo_err   = 1'b0;
    lat        = '0;
    fifo_empty = (occ == '0);
    fifo_full  = (occ == DEPTH);
    if (!clear) begin
      if (resp) begin
        if (!fifo_empty) begin
          do_pop  = 1'b1;
          do_push = req;
          sample  = 1'b1;
          lat     = now - fifo_mem[rd_ptr];
        end else if (req) begin
          // Request and response in the same cycle with nothing queued: zero latency.
          sample = 1'b1;
        end else begin
          fifo_err = 1'b1;
        end
      end else if (req) begin
        if (fifo_full) fifo_err = 1'b1;
        else           do_push  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      occ <= occ + 1'b1;
      else if (do_pop && !do_push) occ <= occ - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= now;
  end

  // ---------------- accumulators ----------------
  logic [SW-1:0] sum, sum_next;
  logic [W-1:0]  cnt, cnt_next, mn, mn_next, mx, mx_next, reqs_n;
  logic          batch_end, start, overrun;
  div_state_t    state, state_next;

  assign reqs_n = W'(ceil_shift(32'(batch_length), LOG2_N_CORES));

  always_comb begin
    sum_next  = sum + SW'(lat);
    cnt_next  = cnt + 1'b1;
    mn_next   = (lat < mn) ? lat : mn;
    mx_next   = (lat > mx) ? lat : mx;
    batch_end = sample && (reqs_n != '0) && (cnt_next == reqs_n);
    start     = batch_end && (state == DIV_IDLE);
    overrun   = batch_end && (state != DIV_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
      cnt <= '0;
      mn  <= '1;
      mx  <= '0;
    end else if (clear || batch_end) begin
      sum <= '0;
      cnt <= '0;
      mn  <= '1;
      mx  <= '0;
    end else if (sample) begin
      sum <= sum_next;
      cnt <= cnt_next;
      mn  <= mn_next;
      mx  <= mx_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 err <= 1'b0;
    else if (clear)             err <= 1'b0;
    else if (fifo_err || overrun) err <= 1'b1;
  end

  // ---------------- divider FSM ----------------
  logic [IW-1:0] iter;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DIV_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      DIV_IDLE: if (start) state_next = DIV_RUN;
      DIV_RUN:  if (iter == LAST_ITER) state_next = DIV_DONE;
      DIV_DONE: state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
    if (clear) state_next = DIV_IDLE;
  end

  assign div_state = state;
  assign valid     = (state == DIV_DONE);

  // Restoring division of the snapshotted sum by the sample count, one quotient bit per cycle.
  logic [SW-1:0] rem, rem_step, quo, quo_step, divisor;
  logic [SW:0]   rem_shift;
  logic [W-1:0]  snap_min, snap_max;

  always_comb begin
    rem_shift = {rem, quo[SW-1]};
    quo_step  = {quo[SW-2:0], 1'b0};
    rem_step  = rem_shift[SW-1:0];
    if (rem_shift >= {1'b0, divisor}) begin
      rem_step    = SW'(rem_shift - {1'b0, divisor});
      quo_step[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      iter     <= '0;
      snap_min <= '0;
      snap_max <= '0;
    end else if (start) begin
      rem      <= '0;
      quo      <= sum_next;
      divisor  <= SW'(cnt_next);
      iter     <= '0;
      snap_min <= mn_next;
      snap_max <= mx_next;
    end else if (state == DIV_RUN) begin
      rem  <= rem_step;
      quo  <= quo_step;
      iter <= iter + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg     <= '0;
      lat_min <= '0;
      lat_max <= '0;
    end else if (state == DIV_RUN && state_next == DIV_DONE) begin
      avg     <= (|quo_step[SW-1:W]) ? '1 : quo_step[W-1:0];
      lat_min <= snap_min;
      lat_max <= snap_max;
    end
  end

endmodule

// File: rtl/roundtrip_latency_monitor_mc.sv
// Multi-channel round-trip latency monitor: shared timestamp counter plus one
// independent rt_mon_channel per accelerator DMA port.
module roundtrip_latency_monitor_mc
  import rt_mon_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int N_CH            = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int LOG2_N_CORES    = 0
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       clear_i,
  input  logic [N_CH-1:0]            acc_req_valid_i,
  input  logic [N_CH-1:0]            mem_data_valid_i,
  input  logic [N_CH*DATA_WIDTH-1:0] batch_length_i,
  output logic [N_CH*DATA_WIDTH-1:0] mon_avg_o,
  output logic [N_CH*DATA_WIDTH-1:0] mon_min_o,
  output logic [N_CH*DATA_WIDTH-1:0] mon_max_o,
  output logic [N_CH-1:0]            mon_valid_o,
  output logic [N_CH-1:0]            mon_err_o,
  output logic [2*N_CH-1:0]          dbg_div_state_o
);

  localparam int W = DATA_WIDTH;

  // Free-running timestamp; clear_i leaves it alone since it is not channel state.
  logic [W-1:0] now;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) now <= '0;
    else         now <= now + 1'b1;
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    rt_mon_channel #(
      .DATA_WIDTH      (DATA_WIDTH),
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .LOG2_N_CORES    (LOG2_N_CORES)
    ) u_ch (
      .clk          (clk_i),
      .rst_n        (rstn_i),
      .clear        (clear_i),
      .req          (acc_req_valid_i[c]),
      .resp         (mem_data_valid_i[c]),
      .now          (now),
      .batch_length (batch_length_i[c*W +: W]),
      .avg          (mon_avg_o[c*W +: W]),
      .lat_min      (mon_min_o[c*W +: W]),
      .lat_max      (mon_max_o[c*W +: W]),
      .valid        (mon_valid_o[c]),
      .err          (mon_err_o[c]),
      .div_state    (dbg_div_state_o[2*c +: 2])
    );
  end

endmodule

// File: tb/tb_roundtrip_latency_monitor_mc.sv
// Directed bench for roundtrip_latency_monitor_mc: a 4-channel instance with
// LOG2_N_CORES=0 and a 1-channel instance with LOG2_N_CORES=2.
module tb_roundtrip_latency_monitor_mc;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  logic clear;
  always #5 clk = ~clk;

  logic [3:0]  req, resp, valid, err;
  logic [63:0] blen, avg, mn, mx;
  logic [7:0]  dbg;

  logic [0:0]  req2, resp2, valid2, err2;
  logic [15:0] blen2, avg2, mn2, mx2;
  logic [1:0]  dbg2;

  int tests_run    = 0;
  int tests_failed = 0;
  int pulse_cnt [4];
  int pulse_cnt2   = 0;
  logic [15:0] tb_now;

  roundtrip_latency_monitor_mc #(
    .DATA_WIDTH(16), .N_CH(4), .MAX_OUTSTANDING(4), .LOG2_N_CORES(0)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .clear_i(clear),
    .acc_req_valid_i(req), .mem_data_valid_i(resp), .batch_length_i(blen),
    .mon_avg_o(avg), .mon_min_o(mn), .mon_max_o(mx),
    .mon_valid_o(valid), .mon_err_o(err), .dbg_div_state_o(dbg)
  );

  roundtrip_latency_monitor_mc #(
    .DATA_WIDTH(16), .N_CH(1), .MAX_OUTSTANDING(4), .LOG2_N_CORES(2)
  ) dut2 (
    .clk_i(clk), .rstn_i(rstn), .clear_i(clear),
    .acc_req_valid_i(req2), .mem_data_valid_i(resp2), .batch_length_i(blen2),
    .mon_avg_o(avg2), .mon_min_o(mn2), .mon_max_o(mx2),
    .mon_valid_o(valid2), .mon_err_o(err2), .dbg_div_state_o(dbg2)
  );

  // Reference model of the shared timestamp counter.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) tb_now <= '0;
    else       tb_now <= tb_now + 16'd1;
  end

  // Publish-pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) if (valid[c] === 1'b1) pulse_cnt[c] <= pulse_cnt[c] + 1;
    if (valid2[0] === 1'b1) pulse_cnt2 <= pulse_cnt2 + 1;
  end

  function automatic logic [15:0] sl(input logic [63:0] v, input int c);
    return v[c*16 +: 16];
  endfunction

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic step(input logic [3:0] rq, input logic [3:0] rs);
    req = rq; resp = rs;
    @(negedge clk);
    req = '0; resp = '0;
  endtask

  task automatic step2(input logic rq, input logic rs);
    req2 = rq; resp2 = rs;
    @(negedge clk);
    req2 = '0; resp2 = '0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    tests_run++; if (avg !== 64'd0) begin tests_failed++; $display("FAIL reset_avg: got %h expected 0", avg); end
    tests_run++; if (mn !== 64'd0) begin tests_failed++; $display("FAIL reset_min: got %h expected 0", mn); end
    tests_run++; if (mx !== 64'd0) begin tests_failed++; $display("FAIL reset_max: got %h expected 0", mx); end
    tests_run++; if (valid !== 4'd0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0000", valid); end
    tests_run++; if (err !== 4'd0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0000", err); end
    tests_run++; if (dbg !== 8'd0) begin tests_failed++; $display("FAIL reset_state: got %h expected 00", dbg); end
    tests_run++; if (avg2 !== 16'd0) begin tests_failed++; $display("FAIL reset_avg2: got %0d expected 0", avg2); end
  endtask

  // Reqs at t=0..3, resps at t=10,12,14,16: lats 10,11,12,13.
  task automatic test_basic();
    int n;
    for (int t = 0; t <= 16; t++)
      step({3'b000, t < 4}, {3'b000, (t == 10) || (t == 12) || (t == 14) || (t == 16)});
    n = 1;
    while (valid[0] !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    tests_run++; if (n != 33) begin tests_failed++; $display("FAIL basic_latency: got %0d cycles expected 33", n); end
    tests_run++; if (sl(avg, 0) !== 16'd11) begin tests_failed++; $display("FAIL basic_avg: got %0d expected 11", sl(avg, 0)); end
    tests_run++; if (sl(mn, 0) !== 16'd10) begin tests_failed++; $display("FAIL basic_min: got %0d expected 10", sl(mn, 0)); end
    tests_run++; if (sl(mx, 0) !== 16'd13) begin tests_failed++; $display("FAIL basic_max: got %0d expected 13", sl(mx, 0)); end
    @(negedge clk);
    tests_run++; if (valid[0] !== 1'b0) begin tests_failed++; $display("FAIL basic_pulse_width: got %b expected 0", valid[0]); end
    tests_run++; if (err !== 4'd0) begin tests_failed++; $display("FAIL basic_err: got %b expected 0000", err); end
  endtask

  // ch1 lat 3; ch2 lats 5,7; ch3 lats 1,2 (with a same-cycle pop/push).
  task automatic test_channels();
    for (int t = 0; t <= 8; t++)
      step({(t == 1) || (t == 2), (t == 0) || (t == 1), t == 0, 1'b0},
           {(t == 2) || (t == 4), (t == 5) || (t == 8), t == 3, 1'b0});
    idle(45);
    tests_run++; if ({sl(avg, 1), sl(mn, 1), sl(mx, 1)} !== {16'd3, 16'd3, 16'd3}) begin tests_failed++;
      $display("FAIL ch1_result: got %0d/%0d/%0d expected 3/3/3", sl(avg, 1), sl(mn, 1), sl(mx, 1)); end
    tests_run++; if ({sl(avg, 2), sl(mn, 2), sl(mx, 2)} !== {16'd6, 16'd5, 16'd7}) begin tests_failed++;
      $display("FAIL ch2_result: got %0d/%0d/%0d expected 6/5/7", sl(avg, 2), sl(mn, 2), sl(mx, 2)); end
    tests_run++; if ({sl(avg, 3), sl(mn, 3), sl(mx, 3)} !== {16'd1, 16'd1, 16'd2}) begin tests_failed++;
      $display("FAIL ch3_result: got %0d/%0d/%0d expected 1/1/2", sl(avg, 3), sl(mn, 3), sl(mx, 3)); end
    tests_run++; if (sl(avg, 0) !== 16'd11) begin tests_failed++; $display("FAIL ch0_held: got %0d expected 11", sl(avg, 0)); end
    tests_run++; if ({pulse_cnt[3], pulse_cnt[2], pulse_cnt[1], pulse_cnt[0]} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin tests_failed++;
      $display("FAIL ch_pulses: got %0d %0d %0d %0d expected 1 1 1 1", pulse_cnt[0], pulse_cnt[1], pulse_cnt[2], pulse_cnt[3]); end
    tests_run++; if (err !== 4'd0) begin tests_failed++; $display("FAIL ch_err: got %b expected 0000", err); end
  endtask

  // Overfill, drain with lats 5, orphan resp, then a bypass sample closes batch of 5.
  task automatic test_fifo_err();
    blen[15:0] = 16'd5;
    for (int t = 0; t <= 10; t++) begin
      step({3'b000, (t <= 4) || (t == 10)}, {3'b000, t >= 5});
      if (t == 4) begin
        tests_run++; if (err[0] !== 1'b1) begin tests_failed++; $display("FAIL overflow_err: got %b expected 1", err[0]); end
      end
    end
    idle(40);
    tests_run++; if ({sl(avg, 0), sl(mn, 0), sl(mx, 0)} !== {16'd4, 16'd0, 16'd5}) begin tests_failed++;
      $display("FAIL fifo_err_result: got %0d/%0d/%0d expected 4/0/5", sl(avg, 0), sl(mn, 0), sl(mx, 0)); end
    tests_run++; if (err[0] !== 1'b1) begin tests_failed++; $display("FAIL err_sticky: got %b expected 1", err[0]); end
    tests_run++; if (pulse_cnt[0] != 2) begin tests_failed++; $display("FAIL fifo_err_pulses: got %0d expected 2", pulse_cnt[0]); end
    pulse_clear();
    tests_run++; if (err[0] !== 1'b0) begin tests_failed++; $display("FAIL clear_err: got %b expected 0", err[0]); end
    tests_run++; if (sl(avg, 0) !== 16'd4) begin tests_failed++; $display("FAIL clear_holds_avg: got %0d expected 4", sl(avg, 0)); end
  endtask

  // Full FIFO with req+resp at t=6: lats 6,6,6,6,4; the t=11 resp finds it empty.
  task automatic test_full_pair();
    for (int t = 0; t <= 11; t++) begin
      step({3'b000, (t <= 3) || (t == 6)}, {3'b000, t >= 6});
      if (t == 6 || t == 10) begin
        tests_run++; if (err[0] !== 1'b0) begin tests_failed++; $display("FAIL full_pair_err t=%0d: got %b expected 0", t, err[0]); end
      end
    end
    tests_run++; if (err[0] !== 1'b1) begin tests_failed++; $display("FAIL full_pair_occupancy: got err %b expected 1", err[0]); end
    idle(40);
    tests_run++; if ({sl(avg, 0), sl(mn, 0), sl(mx, 0)} !== {16'd5, 16'd4, 16'd6}) begin tests_failed++;
      $display("FAIL full_pair_result: got %0d/%0d/%0d expected 5/4/6", sl(avg, 0), sl(mn, 0), sl(mx, 0)); end
    tests_run++; if (pulse_cnt[0] != 3) begin tests_failed++; $display("FAIL full_pair_pulses: got %0d expected 3", pulse_cnt[0]); end
    pulse_clear();
  endtask

  // Req at now=0xFFFE, resp at now=0x0003.
  task automatic test_wrap();
    int k;
    blen[15:0] = 16'd1;
    k = 0;
    while (tb_now !== 16'hFFFE && k < 70000) begin @(negedge clk); k++; end
    if (k >= 70000) begin tests_run++; tests_failed++; $display("FAIL wrap_wait: timed out after %0d cycles", k); end
    step(4'b0001, 4'b0000);
    k = 0;
    while (tb_now !== 16'd3 && k < 10) begin @(negedge clk); k++; end
    step(4'b0000, 4'b0001);
    idle(40);
    tests_run++; if ({sl(avg, 0), sl(mn, 0), sl(mx, 0)} !== {16'd5, 16'd5, 16'd5}) begin tests_failed++;
      $display("FAIL wrap_result: got %0d/%0d/%0d expected 5/5/5", sl(avg, 0), sl(mn, 0), sl(mx, 0)); end
    tests_run++; if (pulse_cnt[0] != 4) begin tests_failed++; $display("FAIL wrap_pulses: got %0d expected 4", pulse_cnt[0]); end
  endtask

  // reqs_n = ceil(5/4) = 2: lats 3,4 publish; second batch 1,2 closes during the divide.
  task automatic test_batch_overlap();
    for (int t = 0; t <= 10; t++) begin
      step2((t == 0) || (t == 1) || (t == 6) || (t == 8), (t == 3) || (t == 5) || (t == 7) || (t == 10));
      if (t == 5) begin
        tests_run++; if (err2[0] !== 1'b0) begin tests_failed++; $display("FAIL overlap_err_early: got %b expected 0", err2[0]); end
      end
    end
    tests_run++; if (err2[0] !== 1'b1) begin tests_failed++; $display("FAIL overlap_err: got %b expected 1", err2[0]); end
    idle(45);
    tests_run++; if ({avg2, mn2, mx2} !== {16'd3, 16'd3, 16'd4}) begin tests_failed++;
      $display("FAIL overlap_result: got %0d/%0d/%0d expected 3/3/4", avg2, mn2, mx2); end
    tests_run++; if (pulse_cnt2 != 1) begin tests_failed++; $display("FAIL overlap_pulses: got %0d expected 1", pulse_cnt2); end
  endtask

  // Partial batch + orphan resp + pending req, then clear; next batch is lats 7,7,7.
  task automatic test_clear_mid();
    blen[15:0] = 16'd3;
    step(4'b0001, 4'b0000);
    step(4'b0000, 4'b0001);
    step(4'b0000, 4'b0001);
    tests_run++; if (err[0] !== 1'b1) begin tests_failed++; $display("FAIL orphan_resp_err: got %b expected 1", err[0]); end
    step(4'b0001, 4'b0000);
    pulse_clear();
    tests_run++; if (err[0] !== 1'b0) begin tests_failed++; $display("FAIL clear_mid_err: got %b expected 0", err[0]); end
    tests_run++; if ({sl(avg, 0), sl(mn, 0), sl(mx, 0)} !== {16'd5, 16'd5, 16'd5}) begin tests_failed++;
      $display("FAIL clear_mid_held: got %0d/%0d/%0d expected 5/5/5", sl(avg, 0), sl(mn, 0), sl(mx, 0)); end
    for (int u = 0; u <= 23; u++)
      step({3'b000, (u == 0) || (u == 8) || (u == 16)}, {3'b000, (u == 7) || (u == 15) || (u == 23)});
    idle(40);
    tests_run++; if ({sl(avg, 0), sl(mn, 0), sl(mx, 0)} !== {16'd7, 16'd7, 16'd7}) begin tests_failed++;
      $display("FAIL clear_mid_result: got %0d/%0d/%0d expected 7/7/7", sl(avg, 0), sl(mn, 0), sl(mx, 0)); end
    tests_run++; if (pulse_cnt[0] != 5) begin tests_failed++; $display("FAIL clear_mid_pulses: got %0d expected 5", pulse_cnt[0]); end
  endtask

  task automatic test_clear_divider();
    blen[15:0] = 16'd1;
    step(4'b0001, 4'b0001);
    idle(5);
    pulse_clear();
    idle(40);
    tests_run++; if (pulse_cnt[0] != 5) begin tests_failed++; $display("FAIL clear_div_pulses: got %0d expected 5", pulse_cnt[0]); end
    tests_run++; if (sl(avg, 0) !== 16'd7) begin tests_failed++; $display("FAIL clear_div_avg: got %0d expected 7", sl(avg, 0)); end
    tests_run++; if (dbg[1:0] !== 2'd0) begin tests_failed++; $display("FAIL clear_div_state: got %0d expected 0", dbg[1:0]); end
  endtask

  task automatic test_reset_mid();
    blen[31:0] = {16'd1, 16'd1};
    step(4'b0011, 4'b0011);
    idle(10);
    tests_run++; if (dbg[3:0] !== 4'b0101) begin tests_failed++; $display("FAIL mid_run_state: got %b expected 0101", dbg[3:0]); end
    rstn = 1'b0;
    #1;
    tests_run++; if ({avg, mn, mx} !== 192'd0) begin tests_failed++; $display("FAIL async_reset_outputs: got %h expected 0", {avg, mn, mx}); end
    tests_run++; if ({avg2, mn2, mx2, err2} !== 49'd0) begin tests_failed++; $display("FAIL async_reset_dut2: got %h expected 0", {avg2, mn2, mx2, err2}); end
    idle(2);
    rstn = 1'b1;
    idle(40);
    tests_run++; if (pulse_cnt[0] != 5 || pulse_cnt[1] != 1) begin tests_failed++;
      $display("FAIL reset_mid_pulses: got %0d/%0d expected 5/1", pulse_cnt[0], pulse_cnt[1]); end
    tests_run++; if ({avg, dbg, err} !== 76'd0) begin tests_failed++; $display("FAIL reset_mid_after: got %h expected 0", {avg, dbg, err}); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rstn  = 1'b0;
    clear = 1'b0;
    req   = '0; resp  = '0;
    req2  = '0; resp2 = '0;
    blen  = {16'd2, 16'd2, 16'd1, 16'd4};
    blen2 = 16'd5;
    for (int c = 0; c < 4; c++) pulse_cnt[c] = 0;
    idle(3);
    rstn = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_channels();
    test_fifo_err();
    test_full_pair();
    test_wrap();
    test_batch_overlap();
    test_clear_mid();
    test_clear_divider();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
